// File: rtl/databus_pattern_injector_if.sv
// rtl/databus_pattern_injector_if.sv - sample data bus bundle for the pattern injector
// Purpose: carries the multi-channel sample bus into and out of the injector.
// Signals:
//   s_data   NOF_CHANNELS*P*B  input sample data, channel-major, sample k at [k*B +: B]
//   m_data   NOF_CHANNELS*P*B  registered output sample data
//   m_marker NOF_CHANNELS      first-pattern-word marker per channel
// Modports:
//   master  the injector: consumes s_data, produces m_data/m_marker
//   slave   the surrounding logic: produces s_data, consumes m_data/m_marker
interface databus_pattern_injector_if #(
  parameter int NOF_CHANNELS     = 2,
  parameter int PARALLEL_SAMPLES = 8,
  parameter int BITS_PER_SAMPLE  = 16
);
  localparam int DATA_W = NOF_CHANNELS * PARALLEL_SAMPLES * BITS_PER_SAMPLE;

  logic [DATA_W-1:0]       s_data;
  logic [DATA_W-1:0]       m_data;
  logic [NOF_CHANNELS-1:0] m_marker;

  modport master (
    input  s_data,
    output m_data,
    output m_marker
  );

  modport slave (
    output s_data,
    input  m_data,
    input  m_marker
  );
endinterface

// File: rtl/databus_pattern_injector.sv
// rtl/databus_pattern_injector.sv - per-channel constant/ramp/alternating test-pattern injector
// Purpose: in the data clock domain, replaces the samples of selected channels with a
//   generated pattern for a burst of N cycles (or until stopped); everything else passes
//   through with one cycle of latency.
// Ports:
//   data_clk_i       data clock
//   data_rst_n_i     asynchronous active-low reset
//   cfg_mode_i       0 passthrough, 1 constant, 2 ramp, 3 alternating
//   cfg_base_i       constant value / ramp start / alternating value
//   cfg_step_i       ramp increment per sample
//   cfg_ch_mask_i    1 = channel receives the pattern
//   cfg_burst_len_i  burst length in cycles, 0 = continuous
//   start_i          1-cycle pulse, begin a burst
//   stop_i           1-cycle pulse, abort a burst
//   bus              sample bus (s_data in, m_data/m_marker out)
//   busy_o           burst in progress
//   done_o           1-cycle pulse on the edge that ends a burst
//   burst_count_o    pattern words emitted in the current/last burst
module databus_pattern_injector #(
  parameter int NOF_CHANNELS     = 2,
  parameter int PARALLEL_SAMPLES = 8,
  parameter int BITS_PER_SAMPLE  = 16,
  parameter int BURST_WIDTH      = 32
) (
  input  logic                    data_clk_i,
  input  logic                    data_rst_n_i,
  input  logic [1:0]              cfg_mode_i,
  input  logic [BITS_PER_SAMPLE-1:0] cfg_base_i,
  input  logic [BITS_PER_SAMPLE-1:0] cfg_step_i,
  input  logic [NOF_CHANNELS-1:0] cfg_ch_mask_i,
  input  logic [BURST_WIDTH-1:0]  cfg_burst_len_i,
  input  logic                    start_i,
  input  logic                    stop_i,
  databus_pattern_injector_if.master bus,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [BURST_WIDTH-1:0]  burst_count_o
);

  localparam int P      = PARALLEL_SAMPLES;
  localparam int B      = BITS_PER_SAMPLE;
  localparam int DATA_W = NOF_CHANNELS * P * B;

  localparam logic [1:0] MODE_CONST = 2'd1;
  localparam logic [1:0] MODE_RAMP  = 2'd2;
  localparam logic [1:0] MODE_ALT   = 2'd3;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } state_e;

  state_e                  state_q, state_d;
  logic [1:0]              mode_q, mode_d;
  logic [B-1:0]            base_q, base_d;
  logic [B-1:0]            step_q, step_d;
  logic [NOF_CHANNELS-1:0] mask_q, mask_d;
  logic [BURST_WIDTH-1:0]  len_q, len_d;
  logic [B-1:0]            acc_q, acc_d;
  logic [BURST_WIDTH-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0]       data_q, data_d;
  logic [NOF_CHANNELS-1:0] marker_q, marker_d;
  logic                    done_q, done_d;

  logic [DATA_W-1:0]       pattern_word;
  logic [BURST_WIDTH-1:0]  cnt_inc;
  logic [B-1:0]            word_step;

  // Ramp advances by one whole word (P samples) per RUN edge.
  assign word_step = step_q * B'(P);

  // Counter saturates so a continuous burst never wraps back to zero.
  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

  // Pattern word built from the shadow config; unmasked channels keep the live input.
  always_comb begin
    pattern_word = bus.s_data;
    for (int c = 0; c < NOF_CHANNELS; c++) begin
      if (mask_q[c]) begin
        for (int k = 0; k < P; k++) begin
          logic [B-1:0] sample;
          sample = base_q;
          case (mode_q)
            MODE_CONST: sample = base_q;
            MODE_RAMP:  sample = acc_q + (B'(k) * step_q);
            MODE_ALT:   sample = k[0] ? ~base_q : base_q;
            default:    sample = base_q;
          endcase
          pattern_word[(c*P + k)*B +: B] = sample;
        end
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    base_d   = base_q;
    step_d   = step_q;
    mask_d   = mask_q;
    len_d    = len_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    data_d   = bus.s_data;
    marker_d = '0;
    done_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_i && !stop_i && (cfg_mode_i != 2'd0)) begin
          state_d = ST_RUN;
          mode_d  = cfg_mode_i;
          base_d  = cfg_base_i;
          step_d  = cfg_step_i;
          mask_d  = cfg_ch_mask_i;
          len_d   = cfg_burst_len_i;
          acc_d   = cfg_base_i;
          cnt_d   = '0;
        end
      end
      ST_RUN: begin
        if (stop_i) begin
          // Abort edge carries passthrough data and does not count as a pattern word.
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          data_d   = pattern_word;
          // The counter is cleared at start, so zero identifies the first word.
          marker_d = (cnt_q == '0) ? mask_q : '0;
          cnt_d    = cnt_inc;
          acc_d    = acc_q + word_step;
          if ((len_q != '0) && (cnt_inc == len_q)) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge data_clk_i or negedge data_rst_n_i) begin
    if (!data_rst_n_i) begin
      state_q  <= ST_IDLE;
      mode_q   <= '0;
      base_q   <= '0;
      step_q   <= '0;
      mask_q   <= '0;
      len_q    <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      data_q   <= '0;
      marker_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      base_q   <= base_d;
      step_q   <= step_d;
      mask_q   <= mask_d;
      len_q    <= len_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      marker_q <= marker_d;
      done_q   <= done_d;
    end
  end

  assign bus.m_data    = data_q;
  assign bus.m_marker  = marker_q;
  assign busy_o        = (state_q == ST_RUN);
  assign done_o        = done_q;
  assign burst_count_o = cnt_q;

endmodule

// File: tb/tb_databus_pattern_injector.sv
// tb/tb_databus_pattern_injector.sv - scoreboard bench for databus_pattern_injector
module tb_databus_pattern_injector;
  localparam int NC = 2;
  localparam int P  = 8;
  localparam int B  = 16;
  localparam int BW = 32;
  localparam int W  = NC * P * B;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [1:0]    cfg_mode;
  logic [B-1:0]  cfg_base;
  logic [B-1:0]  cfg_step;
  logic [NC-1:0] cfg_mask;
  logic [BW-1:0] cfg_len;
  logic          start;
  logic          stop;
  logic          busy;
  logic          done;
  logic [BW-1:0] burst_count;

  databus_pattern_injector_if #(.NOF_CHANNELS(NC), .PARALLEL_SAMPLES(P), .BITS_PER_SAMPLE(B)) bus ();

  databus_pattern_injector #(
    .NOF_CHANNELS(NC), .PARALLEL_SAMPLES(P), .BITS_PER_SAMPLE(B), .BURST_WIDTH(BW)
  ) dut (
    .data_clk_i      (clk),
    .data_rst_n_i    (rst_n),
    .cfg_mode_i      (cfg_mode),
    .cfg_base_i      (cfg_base),
    .cfg_step_i      (cfg_step),
    .cfg_ch_mask_i   (cfg_mask),
    .cfg_burst_len_i (cfg_len),
    .start_i         (start),
    .stop_i          (stop),
    .bus             (bus.master),
    .busy_o          (busy),
    .done_o          (done),
    .burst_count_o   (burst_count)
  );

  typedef struct {
    logic [W-1:0]  data;
    logic [NC-1:0] marker;
    logic          busy;
    logic          done;
    logic [BW-1:0] count;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model: burst described by word index, not by an accumulator.
  bit            m_run = 0;
  logic [1:0]    m_mode;
  logic [B-1:0]  m_base, m_step;
  logic [NC-1:0] m_mask;
  logic [BW-1:0] m_len;
  logic [BW-1:0] m_cnt = '0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  function automatic logic [B-1:0] model_sample(input int w, input int k);
    logic [31:0] idx;
    case (m_mode)
      2'd1: return m_base;
      2'd2: begin
        idx = w * P + k;
        return m_base + idx[B-1:0] * m_step;
      end
      default: return (k % 2 == 1) ? ~m_base : m_base;
    endcase
  endfunction

  function automatic exp_t model_edge(input logic [W-1:0] din, input logic st, input logic sp);
    exp_t e;
    e.data   = din;
    e.marker = '0;
    e.done   = 1'b0;
    if (!m_run) begin
      if (st && !sp && cfg_mode != 2'd0) begin
        m_run  = 1;
        m_mode = cfg_mode;
        m_base = cfg_base;
        m_step = cfg_step;
        m_mask = cfg_mask;
        m_len  = cfg_len;
        m_cnt  = '0;
      end
    end else if (sp) begin
      m_run  = 0;
      e.done = 1'b1;
    end else begin
      for (int c = 0; c < NC; c++)
        if (m_mask[c])
          for (int k = 0; k < P; k++)
            e.data[(c*P + k)*B +: B] = model_sample(int'(m_cnt), k);
      if (m_cnt == 0) e.marker = m_mask;
      m_cnt = m_cnt + 1;
      if (m_len != 0 && m_cnt == m_len) begin
        m_run  = 0;
        e.done = 1'b1;
      end
    end
    e.busy  = m_run;
    e.count = m_cnt;
    return e;
  endfunction

  task automatic rand_data();
    for (int i = 0; i < W / 32; i++) bus.s_data[i*32 +: 32] = $urandom();
  endtask

  // One clock edge: drive inputs, predict, queue expectation at the edge.
  task automatic step(input logic st, input logic sp);
    exp_t e;
    rand_data();
    start = st;
    stop  = sp;
    e = model_edge(bus.s_data, st, sp);
    @(posedge clk);
    exp_q.push_back(e);
    #1;
    start = 1'b0;
    stop  = 1'b0;
  endtask

  // Monitor: compare every registered output once per cycle, away from the edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("m_data", bus.m_data, W'(e.data));
      chk("m_marker", W'(bus.m_marker), W'(e.marker));
      chk("busy", W'(busy), W'(e.busy));
      chk("done", W'(done), W'(e.done));
      chk("burst_count", W'(burst_count), W'(e.count));
    end
  end

  task automatic check_zero(input string tag);
    chk({tag, "_data"}, bus.m_data, '0);
    chk({tag, "_marker"}, W'(bus.m_marker), '0);
    chk({tag, "_busy"}, W'(busy), '0);
    chk({tag, "_done"}, W'(done), '0);
    chk({tag, "_count"}, W'(burst_count), '0);
  endtask

  task automatic set_cfg(input logic [1:0] md, input logic [B-1:0] bs, input logic [B-1:0] sp,
                         input logic [NC-1:0] mk, input logic [BW-1:0] ln);
    cfg_mode = md; cfg_base = bs; cfg_step = sp; cfg_mask = mk; cfg_len = ln;
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    stop  = 1'b0;
    set_cfg(2'd0, '0, '0, '0, '0);

    // 1: reset holds outputs at zero regardless of input data
    for (int i = 0; i < 3; i++) begin
      rand_data();
      @(posedge clk);
      #1;
      check_zero("rst_hold");
    end
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0);

    // 2: ramp crossing zero, channel 0 only, three words
    set_cfg(2'd2, 16'hFFFC, 16'h0001, 2'b01, 32'd3);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    #1;
    chk("t2_first_sample", W'(bus.m_data[B-1:0]), W'(16'hFFFC));
    chk("t2_last_sample", W'(bus.m_data[(P-1)*B +: B]), W'(16'h0003));
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    #1;
    chk("t2_word3_last", W'(bus.m_data[(P-1)*B +: B]), W'(16'h0013));
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
    chk("t2_count_hold", W'(burst_count), W'(32'd3));

    // 3: continuous constant on both channels, aborted after 100 words
    set_cfg(2'd1, 16'h1234, 16'h0000, 2'b11, 32'd0);
    step(1'b1, 1'b0);
    for (int i = 0; i < 100; i++) step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    chk("t3_count", W'(burst_count), W'(32'd100));

    // 4: start ignored in RUN; start+stop in IDLE; start with mode 0
    set_cfg(2'd1, 16'hA5A5, 16'h0000, 2'b10, 32'd5);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    set_cfg(2'd2, 16'h0001, 16'h0002, 2'b11, 32'd2);
    step(1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0);
    step(1'b1, 1'b1);
    #1;
    chk("t4_start_stop_idle", W'(busy), '0);
    set_cfg(2'd0, 16'h5555, 16'h0001, 2'b11, 32'd4);
    step(1'b1, 1'b0);
    #1;
    chk("t4_mode0_idle", W'(busy), '0);
    step(1'b0, 1'b0);

    // 5: alternating pattern, base changes mid-burst must not leak in
    set_cfg(2'd3, 16'h00FF, 16'h0000, 2'b11, 32'd4);
    step(1'b1, 1'b0);
    for (int i = 0; i < 6; i++) begin
      cfg_base = 16'($urandom());
      cfg_mode = 2'($urandom());
      step(1'b0, 1'b0);
    end

    // randomized bursts
    for (int i = 0; i < 600; i++) begin
      set_cfg(2'($urandom()), 16'($urandom()), 16'($urandom()), 2'($urandom()),
              32'($urandom_range(0, 6)));
      step(($urandom() % 4) == 0, ($urandom() % 16) == 0);
    end

    // 6: asynchronous reset between edges during a burst
    set_cfg(2'd2, 16'h0100, 16'h0003, 2'b11, 32'd0);
    step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("async_rst");
    m_run = 0;
    m_cnt = '0;
    @(posedge clk);
    #1;
    check_zero("async_rst_edge");
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0);

    @(negedge clk);
    #2;
    chk("queue_drained", W'(exp_q.size()), '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
